// File: rtl/digit_overlay_ctrl.sv
// Draws an NUM_DIGITS-wide BCD readout into the VGA raster by sequencing shared glyph ROMs.
// Latency: 2 cycles from hcount/vcount/pix_valid to pix_out/pix_out_valid, one pixel per cycle.
// Backpressure: value_ready drops while a value waits for frame_start; the pixel path never stalls.
module digit_overlay_ctrl #(
  parameter int          NUM_DIGITS  = 3,
  parameter int          X0          = 16,
  parameter int          Y0          = 16,
  parameter int          SCALE_SHIFT = 1,
  parameter logic [5:0]  BG_COLOR    = 6'b111111
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    frame_start,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  input  logic                    pix_valid,
  output logic [3:0]              glyph_sel,
  output logic [4:0]              glyph_col,
  output logic [4:0]              glyph_row,
  input  logic [5:0]              glyph_data,
  output logic [5:0]              pix_out,
  output logic                    pix_out_valid
);

  localparam int W       = 8 << SCALE_SHIFT;
  localparam int H       = 16 << SCALE_SHIFT;
  localparam int SLOT_SH = 3 + SCALE_SHIFT;

  localparam logic [10:0] XL    = 11'(X0);
  localparam logic [10:0] YT    = 11'(Y0);
  localparam logic [10:0] XSPAN = 11'(NUM_DIGITS * W);
  localparam logic [10:0] YSPAN = 11'(H);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                  state, state_nxt;
  logic                    accept, commit;
  logic [4*NUM_DIGITS-1:0] pending, display, display_nxt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (value_valid && value_ready) begin
          accept    = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (frame_start) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1 looks at the post-commit display so a frame_start pixel already shows the new value.
  assign display_nxt = commit ? pending : display;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      value_ready <= 1'b0;
      pending     <= '1;
      display     <= '1;
    end else begin
      state       <= state_nxt;
      value_ready <= (state_nxt == IDLE);
      if (accept) pending <= value_bcd;
      display     <= display_nxt;
    end
  end

  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zero_left;
  logic [3:0]            dig;

  always_comb begin
    blank_vec = '0;
    zero_left = 1'b1;
    dig       = 4'h0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      dig          = display_nxt[4*k +: 4];
      blank_vec[k] = (dig > 4'd9) || ((k != 0) && zero_left && (dig == 4'd0));
      zero_left    = zero_left && (dig == 4'd0);
    end
  end

  logic [10:0] hx, vy, dx, dy, slot_idx;
  logic        hit_c, blank_c;
  logic [3:0]  sel_c;

  assign hx       = {1'b0, hcount};
  assign vy       = {1'b0, vcount};
  assign dx       = hx - XL;
  assign dy       = vy - YT;
  assign slot_idx = dx >> SLOT_SH;
  assign hit_c    = pix_valid && (hx >= XL) && (dx < XSPAN) && (vy >= YT) && (dy < YSPAN);

  always_comb begin
    sel_c   = 4'h0;
    blank_c = 1'b0;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      if (slot_idx == 11'(s)) begin
        sel_c   = display_nxt[4*(NUM_DIGITS-1-s) +: 4];
        blank_c = blank_vec[NUM_DIGITS-1-s];
      end
    end
  end

  logic hit1, blank1, pv1;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit1          <= 1'b0;
      blank1        <= 1'b0;
      pv1           <= 1'b0;
      glyph_sel     <= 4'h0;
      glyph_col     <= 5'd0;
      glyph_row     <= 5'd0;
      pix_out       <= BG_COLOR;
      pix_out_valid <= 1'b0;
    end else begin
      hit1          <= hit_c;
      blank1        <= hit_c && blank_c;
      pv1           <= pix_valid;
      glyph_sel     <= hit_c ? sel_c : 4'h0;
      glyph_col     <= hit_c ? 5'(dx[2+SCALE_SHIFT:SCALE_SHIFT]) : 5'd0;
      glyph_row     <= hit_c ? 5'(dy[3+SCALE_SHIFT:SCALE_SHIFT]) : 5'd0;
      pix_out       <= (hit1 && !blank1) ? glyph_data : BG_COLOR;
      pix_out_valid <= pv1;
    end
  end

endmodule

// File: tb/tb_digit_overlay_ctrl.sv
// Random raster/handshake stimulus against a frame-level model of the digit overlay.
// A small bench ROM feeds glyph_data back from the DUT's glyph select/column/row.
module tb_digit_overlay_ctrl;

  localparam logic [5:0] BG = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] value_bcd;
  logic        value_valid, value_ready, frame_start, pix_valid, pix_out_valid;
  logic [9:0]  hcount, vcount;
  logic [3:0]  glyph_sel;
  logic [4:0]  glyph_col, glyph_row;
  logic [5:0]  glyph_data, pix_out;

  always #5 clk = ~clk;

  digit_overlay_ctrl dut (
    .clk(clk), .reset(reset), .value_bcd(value_bcd), .value_valid(value_valid),
    .value_ready(value_ready), .frame_start(frame_start), .hcount(hcount), .vcount(vcount),
    .pix_valid(pix_valid), .glyph_sel(glyph_sel), .glyph_col(glyph_col), .glyph_row(glyph_row),
    .glyph_data(glyph_data), .pix_out(pix_out), .pix_out_valid(pix_out_valid)
  );

  function automatic logic [5:0] rom(input logic [3:0] s, input logic [4:0] c, input logic [4:0] r);
    if (s == 4'd4 && c == 5'd1 && r == 5'd1) return 6'b000000;
    return {s[1:0], c[1:0] ^ r[1:0], r[3:2] ^ {1'b0, s[2]}};
  endfunction

  assign glyph_data = rom(glyph_sel, glyph_col, glyph_row);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: handshake, committed digits, expected stage-1 and stage-2 outputs.
  bit          m_ready, m_pfull;
  logic [11:0] m_pend, m_disp;
  bit          e_hit, e_blank, e_pv, e_pixv;
  logic [3:0]  e_sel;
  logic [4:0]  e_col, e_row;
  logic [5:0]  e_pix;

  task automatic model_reset();
    m_ready = 0; m_pfull = 0; m_pend = 12'hFFF; m_disp = 12'hFFF;
    e_hit = 0; e_blank = 0; e_pv = 0; e_pixv = 0;
    e_sel = 0; e_col = 0; e_row = 0; e_pix = BG;
  endtask

  task automatic model_step();
    logic [11:0] shown;
    int x, y, slot;
    bit lead_zero;
    logic [3:0] d;
    if (reset) begin
      model_reset();
      return;
    end
    e_pix  = (e_hit && !e_blank) ? rom(e_sel, e_col, e_row) : BG;
    e_pixv = e_pv;
    shown  = (m_pfull && frame_start) ? m_pend : m_disp;
    if (m_pfull && frame_start) m_pfull = 0;
    else if (!m_pfull && m_ready && value_valid) begin
      m_pend  = value_bcd;
      m_pfull = 1;
    end
    m_disp  = shown;
    m_ready = !m_pfull;

    x = int'(hcount) - 16;
    y = int'(vcount) - 16;
    e_pv  = pix_valid;
    e_hit = pix_valid && x >= 0 && x < 48 && y >= 0 && y < 32;
    e_sel = 0; e_col = 0; e_row = 0; e_blank = 0;
    if (e_hit) begin
      slot  = x / 16;
      d     = shown[4*(2-slot) +: 4];
      e_sel = d;
      e_col = 5'((x % 16) / 2);
      e_row = 5'(y / 2);
      lead_zero = 1;
      for (int j = 0; j < slot; j++)
        if (shown[4*(2-j) +: 4] != 4'd0) lead_zero = 0;
      e_blank = (d > 4'd9) || (slot < 2 && d == 4'd0 && lead_zero);
    end
  endtask

  initial begin
    int rst_hold;
    int phase;
    reset = 1; value_bcd = 12'h172; value_valid = 0; frame_start = 0;
    hcount = 0; vcount = 0; pix_valid = 0;
    model_reset();
    rst_hold = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      chk("value_ready", 32'(value_ready), 32'(m_ready));
      chk("glyph_sel", 32'(glyph_sel), 32'(e_sel));
      chk("glyph_col", 32'(glyph_col), 32'(e_col));
      chk("glyph_row", 32'(glyph_row), 32'(e_row));
      chk("pix_out", 32'(pix_out), 32'(e_pix));
      chk("pix_out_valid", 32'(pix_out_valid), 32'(e_pixv));

      if (cyc < 3) reset = 1;
      else if (rst_hold > 0) begin
        reset = 1;
        rst_hold--;
      end else begin
        reset = ($urandom % 400 == 0);
        if (reset) rst_hold = $urandom_range(0, 2);
      end
      phase = cyc / 600;
      case (phase)
        0: value_bcd = 12'h172;
        1: value_bcd = 12'h004;
        2: value_bcd = 12'h000;
        3: value_bcd = 12'h0A5;
        4: value_bcd = 12'h3B0;
        5: value_bcd = 12'h100;
        default: value_bcd = ($urandom % 4 == 0) ? 12'($urandom) :
                   {4'($urandom % 10 * ($urandom % 2)), 4'($urandom % 10), 4'($urandom % 10)};
      endcase
      value_valid = ($urandom % 3 == 0);
      frame_start = ($urandom % 30 == 0);
      hcount      = 10'($urandom_range(8, 72));
      vcount      = 10'($urandom_range(8, 56));
      pix_valid   = ($urandom % 8 != 0);
      model_step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/digit_overlay_ctrl.md
# digit_overlay_ctrl

Sequences the per-digit glyph ROMs (8×16 cells, 6-bit colour, white background) to draw an NUM_DIGITS-wide height readout onto the VGA raster. Accepts a new BCD value through a valid/ready handshake, commits it only at frame start so the display never tears, and maps each raster coordinate to a digit slot and a glyph column/row. It drives the shared ROM select/address lines and returns the final pixel colour to the VGA output stage, with fixed pipeline latency.

## Interface
- NUM_DIGITS, 3, number of digit slots, MSD leftmost
- X0, 16, left edge of digit box in pixels
- Y0, 16, top edge of digit box in pixels
- SCALE_SHIFT, 1, glyph magnification = 2^SCALE_SHIFT (0..2)
- BG_COLOR, 6'b111111, colour outside glyphs and for blanked digits
- clk  in  1  pixel clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- value_bcd  in  4*NUM_DIGITS  BCD height, digit NUM_DIGITS-1 in MSBs (leftmost)
- value_valid  in  1  value_bcd is offered
- value_ready  out  1  controller can accept a value
- frame_start  in  1  one-cycle pulse at first pixel of a frame
- hcount  in  10  raster x
- vcount  in  10  raster y
- pix_valid  in  1  hcount/vcount in active area
- glyph_sel  out  4  digit code driving the ROM mux
- glyph_col  out  5  glyph column to ROMs (0..7)
- glyph_row  out  5  glyph row to ROMs (0..15)
- glyph_data  in  6  combinational ROM mux output for current glyph_sel/col/row
- pix_out  out  6  final pixel colour
- pix_out_valid  out  1  pix_valid delayed to align with pix_out

## Operation
- Handshake FSM, two states. IDLE: value_ready=1; value_valid&&value_ready captures value_bcd into pending register → PENDING. PENDING: value_ready=0; frame_start copies pending → display register → IDLE. value_ready is registered (= next state is IDLE).
- value_valid and frame_start together in IDLE: value accepted into pending; commit waits for the NEXT frame_start, never the same cycle.
- value_valid held in PENDING: ignored, no overwrite; source must hold until ready.
- Leading-zero blanking on display register: a digit is blank if it is 0 and all digits left of it are 0; the rightmost digit is never blanked for value 0. Any digit code > 9 is blank.
- Geometry: W = 8<<SCALE_SHIFT, H = 16<<SCALE_SHIFT. Hit when pix_valid, Y0 ≤ vcount < Y0+H, X0 ≤ hcount < X0+NUM_DIGITS*W. Slot i = (hcount−X0)/W (0 = leftmost); col = ((hcount−X0) mod W)>>SCALE_SHIFT; row = (vcount−Y0)>>SCALE_SHIFT. Arithmetic in 11 bits, no wrap; coordinates left/above origin are misses.
- glyph_sel = display digit of slot i on hit, 0 on miss; col/row 0 on miss.
- pix_out = glyph_data when hit and slot not blank, else BG_COLOR.

## Timing
- Reset values: state IDLE, value_ready 0 (rises 1 cycle after reset released), pending and display registers all 4'hF (all blank), glyph_sel/col/row 0, pix_out BG_COLOR, pix_out_valid 0, pipeline hit/blank flags 0.
- Stage 1 (cycle N+1): registered hit, blank, glyph_sel, glyph_col, glyph_row from inputs sampled at N.
- glyph_data is sampled at N+1 (combinational ROM), stage 2 (cycle N+2): pix_out, pix_out_valid registered. Total latency 2 cycles, one pixel per cycle, no stalls.
- Display register updates on the cycle after frame_start; pixels sampled in the frame_start cycle already see the new value since their stage-1 blank/sel reads it at N+1.
- Reset mid-frame or mid-PENDING: pending value discarded, display blanked, pipeline flushed to reset values on the next edge.

## Test plan
- Reset, offer 0x172 with valid, pulse frame_start → value_ready 1→0→1; pixel at (X0, Y0+2·2) SCALE_SHIFT=1 gives glyph_sel 1, col 0, row 2; pix_out follows glyph_data 2 cycles later.
- Value 0x004 → slots 0,1 output BG_COLOR for every pixel; slot 2 glyph_sel 4, pix_out 6'b000000 at col 1/row 1 through ROM.
- Value 0x000 → only rightmost slot drawn; digit code 0xA in any slot → that slot BG_COLOR.
- value_valid with frame_start same cycle in IDLE → display unchanged this frame, updated after next frame_start; second value during PENDING is not accepted (ready 0).
- Raster sweep of pixels at X0−1, X0+3·W, Y0+H and pix_valid=0 → pix_out BG_COLOR, pix_out_valid matches pix_valid delayed 2.
- Assert reset during PENDING mid-frame → value_ready 0, pix_out BG_COLOR next cycle, all slots blank after release.
